// File: rtl/alu_cmd_issuer.sv
// Command front-end for the one-hot-select ALU: issues a command, waits
// LAT cycles, samples and checks the result, then returns it with stats.
module alu_cmd_issuer #(
  parameter int W   = 4,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [5:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [2:0]   rsp_op,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [15:0]  done_cnt,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [3:0]   cnt;
  logic         accept;
  logic         sample;
  logic         mismatch;
  logic [5:0]   sel_enc;
  logic [W-1:0] golden;

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign sample    = (state == DRIVE) && (cnt == 4'd0);
  assign mismatch  = (alu_result != golden);

  always_comb begin
    sel_enc = 6'b000000;
    unique case (cmd_op)
      3'd0:    sel_enc = 6'b000001;
      3'd1:    sel_enc = 6'b000010;
      3'd2:    sel_enc = 6'b000100;
      3'd3:    sel_enc = 6'b001000;
      3'd4:    sel_enc = 6'b010000;
      3'd5:    sel_enc = 6'b100000;
      default: sel_enc = 6'b000000;
    endcase
  end

  // Reference value from the captured operands, independent of alu_a/alu_b
  always_comb begin
    golden = '0;
    unique case (op_q)
      3'd0:    golden = a_q + b_q;
      3'd1:    golden = a_q - b_q;
      3'd2:    golden = a_q & b_q;
      3'd3:    golden = a_q ^ b_q;
      3'd4:    golden = ~a_q;
      3'd5:    golden = ~b_q;
      default: golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_op   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      done_cnt <= '0;
      err_cnt  <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      a_q     <= cmd_a;
      b_q     <= cmd_b;
      alu_sel <= sel_enc;
      alu_a   <= cmd_a;
      alu_b   <= cmd_b;
      cnt     <= LAT_M1;
    end else if (sample) begin
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_op   <= op_q;
      rsp_data <= alu_result;
      rsp_err  <= mismatch;
      done_cnt <= done_cnt + 16'd1;
      if (mismatch && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end else if (state == DRIVE) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential command front-end for the combinational one-hot-select ALU (add, sub, and, xor, not-a, not-b, zero). It accepts opcode/operand commands over a valid/ready handshake and encodes each opcode into the ALU's 6-bit priority select. It drives select and operands for a fixed number of cycles, samples the ALU result, and checks it against an internal golden model. It then returns the result, an error flag and running statistics over a second valid/ready handshake. ALU inputs are zeroed whenever no command is in flight, to suppress toggling.

## Interface
- W, 4: operand/result width.
- LAT, 1: cycles the ALU inputs are driven before the result is sampled; legal range 1..15.

- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- alu_sel  out  6  one-hot select to the ALU.
- alu_a  out  W  operand to the ALU.
- alu_b  out  W  operand to the ALU.
- alu_result  in  W  ALU output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_op  out  3  opcode of the response.
- rsp_data  out  W  sampled alu_result.
- rsp_err  out  1  rsp_data differs from the golden value.
- done_cnt  out  16  completed responses; wraps at 65535 -> 0.
- err_cnt  out  8  responses with rsp_err=1; saturates at 255.

## Operation
- Opcode to alu_sel / golden value (all arithmetic mod 2^W):
  - 0 -> 000001, a+b
  - 1 -> 000010, a-b (two's-complement wrap)
  - 2 -> 000100, a&b
  - 3 -> 001000, a^b
  - 4 -> 010000, ~a
  - 5 -> 100000, ~b
  - 6 and 7 -> 000000, 0
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture op, a and b, and go to DRIVE.
  - DRIVE: alu_sel/alu_a/alu_b are registered from the captured command and held constant. A down-counter loaded with LAT-1 decrements each cycle. On the edge where the counter is 0, do all of the following, then go to RESP:
    - capture alu_result into rsp_data;
    - set rsp_err = (alu_result != golden);
    - increment done_cnt;
    - increment err_cnt if rsp_err.
  - RESP: rsp_valid=1 and rsp_op/rsp_data/rsp_err are held stable. On rsp_valid&&rsp_ready, go to IDLE.
- alu_sel, alu_a and alu_b are 0 in IDLE and RESP.
- cmd_ready=0 in DRIVE and RESP. A cmd_valid seen in those states is neither captured nor dropped; the producer keeps holding it.
- A command is never accepted in the same cycle a response completes. IDLE is always entered for at least one cycle.
- The golden value is computed from the captured operands, never from alu_a/alu_b.

## Timing
- Reset (rst high at an edge) sets the following next cycle:
  - state=IDLE;
  - alu_sel, alu_a, alu_b, rsp_valid, rsp_op, rsp_data, rsp_err = 0;
  - done_cnt, err_cnt = 0.
- cmd_ready is gated low while rst is high.
- Reset mid-DRIVE or mid-RESP abandons the command. No response is issued and no counters are updated.
- Accept at edge T:
  - ALU inputs valid in cycles T+1 .. T+LAT.
  - Result sampled at edge T+LAT.
  - rsp_valid high from cycle T+LAT+1.
- With rsp_ready held high, the response completes at edge T+LAT+1, and cmd_ready is high again in cycle T+LAT+2.
- Minimum command period: LAT+2 cycles.
- Counter updates are visible in the same cycle rsp_valid first rises.

## Test plan
- W=4, LAT=1, ALU model attached. Send op0 a=3 b=C:
  - alu_sel=000001 for exactly 1 cycle;
  - rsp_data=F, rsp_err=0, done_cnt=1;
  - rsp_valid rises 2 cycles after accept.
- Arithmetic wrap:
  - op0 a=F b=F -> rsp_data=E.
  - op1 a=3 b=C -> rsp_data=7.
  - op5 b=C -> rsp_data=3.
  - In all three: rsp_err=0.
- Fault injection: force the model output to 0 for op2 a=F b=F (golden F):
  - rsp_err=1, err_cnt=1.
  - Then send 300 faulty commands: err_cnt stays at 255.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 asserted for a second command:
  - rsp_valid, rsp_data and rsp_op stay stable;
  - cmd_ready=0 and alu_sel=0 throughout;
  - second command is accepted only after the response completes plus one IDLE cycle.
- Reset during DRIVE (LAT=3, rst high for one cycle at cycle 2 of DRIVE):
  - alu_sel/alu_a/alu_b=0 on the next cycle;
  - no rsp_valid ever for that command;
  - done_cnt=0.
- LAT=3: op6 and op7 with a=A b=5:
  - alu_sel=000000;
  - rsp_data=0, rsp_err=0;
  - rsp_valid rises exactly 4 cycles after accept.
